// File: rtl/ship_motion_ctrl_if.sv
// Ship motion controller bus: button/tick inputs toward the controller and
// ship column plus status flags back to the renderer and collision logic.
interface ship_motion_ctrl_if #(
  parameter int X_WIDTH = 5
);
  logic               i_tick;
  logic               i_left_debounced;
  logic               i_right_debounced;
  logic               i_freeze;
  logic [X_WIDTH-1:0] o_ship_x;
  logic [1:0]         o_dir;
  logic               o_moving;
  logic               o_at_left;
  logic               o_at_right;

  modport master (
    output i_tick, i_left_debounced, i_right_debounced, i_freeze,
    input  o_ship_x, o_dir, o_moving, o_at_left, o_at_right
  );

  modport slave (
    input  i_tick, i_left_debounced, i_right_debounced, i_freeze,
    output o_ship_x, o_dir, o_moving, o_at_left, o_at_right
  );
endinterface

// File: rtl/ship_motion_ctrl.sv
// Horizontal motion controller for the player ship.
// Direction FSM, move-rate prescaler on i_tick, hold-to-accelerate and
// limit handling. Limits clamp by default; define SHIP_MOTION_WRAP_EN to
// make the ship wrap from one edge of the field to the other instead.
//
// state | meaning
// IDLE  | no single button held, or frozen; counters parked
// LEFT  | left held alone; ticks step the ship toward LEFT_LIMIT
// RIGHT | right held alone; ticks step the ship toward RIGHT_LIMIT
module ship_motion_ctrl #(
  parameter int X_WIDTH     = 5,
  parameter int LEFT_LIMIT  = 0,
  parameter int RIGHT_LIMIT = 19,
  parameter int RESET_POS   = 5,
  parameter int STEP_DIV    = 2,
  parameter int ACCEL_HOLD  = 4,
  parameter int FAST_STEP   = 2
) (
  input  logic               i_clk_25MHz,
  input  logic               i_reset,
  ship_motion_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10
  } dir_t;

  // Two guard bits so x+step and x-step never overflow the signed math.
  localparam int SW     = X_WIDTH + 2;
  localparam int DIV_W  = (STEP_DIV < 2) ? 1 : $clog2(STEP_DIV);
  localparam int HOLD_W = (ACCEL_HOLD < 1) ? 1 : $clog2(ACCEL_HOLD + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_HOLD);

  localparam logic signed [SW-1:0] LEFT_S  = SW'(LEFT_LIMIT);
  localparam logic signed [SW-1:0] RIGHT_S = SW'(RIGHT_LIMIT);
  localparam logic signed [SW-1:0] FAST_S  = SW'(FAST_STEP);
  localparam logic signed [SW-1:0] ONE_S   = SW'(1);
`ifdef SHIP_MOTION_WRAP_EN
  localparam logic signed [SW-1:0] SPAN_S  = SW'(RIGHT_LIMIT - LEFT_LIMIT + 1);
`endif

  dir_t                state_q;
  dir_t                req;
  logic [X_WIDTH-1:0]  x_q;
  logic                moving_q;
  logic [DIV_W-1:0]    div_q;
  logic [HOLD_W-1:0]   hold_q;

  logic                changed;
  logic [DIV_W-1:0]    div_eff;
  logic [HOLD_W-1:0]   hold_eff;
  logic                step_ev;
  logic                do_move;
  logic signed [SW-1:0] x_s;
  logic signed [SW-1:0] step_s;
  logic signed [SW-1:0] sum_s;
  logic [X_WIDTH-1:0]  x_next;

  // Requested direction from the button levels; freeze forces idle.
  always_comb begin
    req = IDLE;
    if (!bus.i_freeze) begin
      if (bus.i_left_debounced && !bus.i_right_debounced)
        req = LEFT;
      else if (bus.i_right_debounced && !bus.i_left_debounced)
        req = RIGHT;
    end
  end

  // Step decision and next column. A direction change restarts the counters
  // in the same cycle, so a tick coinciding with the change moves at step 1.
  always_comb begin
    changed  = (req != state_q);
    div_eff  = changed ? DIV_LAST : div_q;
    hold_eff = changed ? '0 : hold_q;
    step_ev  = (req != IDLE) && bus.i_tick;
    do_move  = step_ev && (div_eff == DIV_LAST);
    x_s      = SW'({2'b00, x_q});
    step_s   = (hold_eff >= HOLD_MAX) ? FAST_S : ONE_S;
    sum_s    = (req == LEFT) ? (x_s - step_s) : (x_s + step_s);
    x_next   = X_WIDTH'(sum_s);
`ifdef SHIP_MOTION_WRAP_EN
    if ((req == LEFT) && (sum_s < LEFT_S))
      x_next = X_WIDTH'(sum_s + SPAN_S);
    else if ((req == RIGHT) && (sum_s > RIGHT_S))
      x_next = X_WIDTH'(sum_s - SPAN_S);
`else
    if ((req == LEFT) && (sum_s < LEFT_S))
      x_next = X_WIDTH'(LEFT_S);
    else if ((req == RIGHT) && (sum_s > RIGHT_S))
      x_next = X_WIDTH'(RIGHT_S);
`endif
  end

  // Direction FSM with prescaler, hold counter and registered position.
  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      state_q  <= IDLE;
      x_q      <= X_WIDTH'(RESET_POS);
      moving_q <= 1'b0;
      div_q    <= DIV_LAST;
      hold_q   <= '0;
    end else begin
      state_q  <= req;
      div_q    <= div_eff;
      hold_q   <= hold_eff;
      moving_q <= 1'b0;
      if (step_ev) begin
        if (do_move) begin
          div_q    <= '0;
          x_q      <= x_next;
          moving_q <= (x_next != x_q);
          if (hold_eff != HOLD_MAX)
            hold_q <= hold_eff + HOLD_W'(1);
        end else begin
          div_q <= div_eff + DIV_W'(1);
        end
      end
    end
  end

  assign bus.o_ship_x   = x_q;
  assign bus.o_dir      = state_q;
  assign bus.o_moving   = moving_q;
  assign bus.o_at_left  = (x_q == X_WIDTH'(LEFT_LIMIT));
  assign bus.o_at_right = (x_q == X_WIDTH'(RIGHT_LIMIT));

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Bench for ship_motion_ctrl: a behavioural model pushes the expected outputs
// of every driven cycle into a queue; they are popped and compared once the
// DUT has clocked that cycle. Explicit checks pin the key positions.
module tb_ship_motion_ctrl;
  localparam int XW        = 5;
  localparam int LEFT_LIM  = 0;
  localparam int RIGHT_LIM = 19;
  localparam int RST_POS   = 5;
  localparam int DIVN      = 2;
  localparam int ACC       = 4;
  localparam int FAST      = 2;
  localparam int SPAN      = RIGHT_LIM - LEFT_LIM + 1;
`ifdef SHIP_MOTION_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic i_clk_25MHz = 1'b0;
  logic i_reset;

  always #20 i_clk_25MHz = ~i_clk_25MHz;

  ship_motion_ctrl_if #(.X_WIDTH(XW)) bus ();

  ship_motion_ctrl #(
    .X_WIDTH(XW), .LEFT_LIMIT(LEFT_LIM), .RIGHT_LIMIT(RIGHT_LIM),
    .RESET_POS(RST_POS), .STEP_DIV(DIVN), .ACCEL_HOLD(ACC), .FAST_STEP(FAST)
  ) dut (
    .i_clk_25MHz(i_clk_25MHz),
    .i_reset(i_reset),
    .bus(bus.slave)
  );

  typedef struct {
    int x;
    int dir;
    int mov;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int m_x, m_dir, m_tk, m_hold, m_mov;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: m_tk counts ticks within a move period, a move on 0.
  task automatic model_step(input bit rst, input bit l, input bit r, input bit frz, input bit tk);
    int req, stp, nx;
    if (rst) begin
      m_x = RST_POS; m_dir = 0; m_mov = 0; m_hold = 0; m_tk = 0;
      return;
    end
    req = 0;
    if (!frz && l && !r) req = 1;
    if (!frz && r && !l) req = 2;
    if (req != m_dir) begin
      m_dir = req; m_hold = 0; m_tk = 0;
    end
    m_mov = 0;
    if (m_dir != 0 && tk) begin
      if (m_tk == 0) begin
        stp = (m_hold >= ACC) ? FAST : 1;
        nx  = (m_dir == 1) ? m_x - stp : m_x + stp;
        if (WRAP) begin
          if (nx < LEFT_LIM)  nx = nx + SPAN;
          if (nx > RIGHT_LIM) nx = nx - SPAN;
        end else begin
          if (nx < LEFT_LIM)  nx = LEFT_LIM;
          if (nx > RIGHT_LIM) nx = RIGHT_LIM;
        end
        m_mov = (nx != m_x) ? 1 : 0;
        m_x   = nx;
        if (m_hold < ACC) m_hold++;
      end
      m_tk = (m_tk + 1) % DIVN;
    end
  endtask

  // One clock: drive at the falling edge, predict, then compare one cycle later.
  task automatic cyc(input bit rst, input bit l, input bit r, input bit frz, input bit tk);
    exp_t e;
    i_reset               = rst;
    bus.i_left_debounced  = l;
    bus.i_right_debounced = r;
    bus.i_freeze          = frz;
    bus.i_tick            = tk;
    model_step(rst, l, r, frz, tk);
    e.x = m_x; e.dir = m_dir; e.mov = m_mov;
    sb_q.push_back(e);
    @(posedge i_clk_25MHz);
    @(negedge i_clk_25MHz);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_x",       32'(bus.o_ship_x),   32'(e.x));
      chk("sb_dir",     32'(bus.o_dir),      32'(e.dir));
      chk("sb_moving",  32'(bus.o_moving),   32'(e.mov));
      chk("sb_at_left", 32'(bus.o_at_left),  32'(e.x == LEFT_LIM));
      chk("sb_at_right",32'(bus.o_at_right), 32'(e.x == RIGHT_LIM));
    end
  endtask

  task automatic run(input bit l, input bit r, input bit frz, input bit tk, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, l, r, frz, tk);
  endtask

  initial begin
    i_reset               = 1'b1;
    bus.i_left_debounced  = 1'b0;
    bus.i_right_debounced = 1'b0;
    bus.i_freeze          = 1'b0;
    bus.i_tick            = 1'b0;
    @(negedge i_clk_25MHz);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_x",     32'(bus.o_ship_x),   32'd5);
    chk("rst_dir",   32'(bus.o_dir),      32'd0);
    chk("rst_mov",   32'(bus.o_moving),   32'd0);
    chk("rst_atl",   32'(bus.o_at_left),  32'd0);
    chk("rst_atr",   32'(bus.o_at_right), 32'd0);

    run(1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("idle_tick_x", 32'(bus.o_ship_x), 32'd5);

    run(1'b0, 1'b1, 1'b0, 1'b0, 1);
    chk("right_dir", 32'(bus.o_dir), 32'd2);
    run(1'b0, 1'b1, 1'b0, 1'b1, 9);
    chk("accel_x", 32'(bus.o_ship_x), 32'd11);

    run(1'b0, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 1);
    chk("left_step1_x", 32'(bus.o_ship_x), 32'd10);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1);

    run(1'b0, 1'b1, 1'b0, 1'b0, 1);
    run(1'b0, 1'b1, 1'b0, 1'b1, 11);
    chk("pre_limit_x", 32'(bus.o_ship_x), 32'd18);
    run(1'b0, 1'b1, 1'b0, 1'b1, 2);
    chk("limit_x",   32'(bus.o_ship_x),   WRAP ? 32'd0 : 32'd19);
    chk("limit_atr", 32'(bus.o_at_right), WRAP ? 32'd0 : 32'd1);
    chk("limit_mov", 32'(bus.o_moving),   32'd1);
    run(1'b0, 1'b1, 1'b0, 1'b1, 2);
    chk("past_limit_x",   32'(bus.o_ship_x), WRAP ? 32'd2 : 32'd19);
    chk("past_limit_mov", 32'(bus.o_moving), WRAP ? 32'd1 : 32'd0);

    run(1'b1, 1'b1, 1'b0, 1'b1, 3);
    chk("both_dir", 32'(bus.o_dir),    32'd0);
    chk("both_x",   32'(bus.o_ship_x), WRAP ? 32'd2 : 32'd19);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 1);
    chk("release_x",   32'(bus.o_ship_x), WRAP ? 32'd1 : 32'd18);
    chk("release_dir", 32'(bus.o_dir),    32'd1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 8);
    chk("fast_left_x", 32'(bus.o_ship_x), WRAP ? 32'd16 : 32'd13);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1);
    run(1'b0, 1'b1, 1'b0, 1'b1, 1);
    chk("reverse_x", 32'(bus.o_ship_x), WRAP ? 32'd17 : 32'd14);

    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 3);
    run(1'b1, 1'b0, 1'b1, 1'b1, 4);
    chk("freeze_dir", 32'(bus.o_dir),    32'd0);
    chk("freeze_x",   32'(bus.o_ship_x), WRAP ? 32'd15 : 32'd12);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 1);
    chk("unfreeze_x", 32'(bus.o_ship_x), WRAP ? 32'd14 : 32'd11);

    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_x", 32'(bus.o_ship_x), 32'd5);

    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 7);
    chk("edge_x1", 32'(bus.o_ship_x), 32'd1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 1);
    chk("edge_x0",  32'(bus.o_ship_x),  32'd0);
    chk("edge_atl", 32'(bus.o_at_left), 32'd1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 1);
    chk("left_edge_x",   32'(bus.o_ship_x), WRAP ? 32'd19 : 32'd0);
    chk("left_edge_mov", 32'(bus.o_moving), WRAP ? 32'd1 : 32'd0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 9);
    chk("fast_edge_x", 32'(bus.o_ship_x), WRAP ? 32'd19 : 32'd0);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1);
    run(1'b0, 1'b1, 1'b0, 1'b1, 1);
    chk("right_edge_x", 32'(bus.o_ship_x), WRAP ? 32'd0 : 32'd1);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end
endmodule
